// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the five-stage pipeline sequencer: FSM encoding and
// architectural constants.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } pipe_state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the destination of a
// load still sitting in EX.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_reg_we,
    input  logic       ex_mem_re,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
    always_comb begin
        rs1_hit  = id_use_rs1 & (id_rs1 == ex_rd);
        rs2_hit  = id_use_rs2 & (id_rs2 == ex_rd);
        load_use = ex_mem_re & ex_reg_we & (ex_rd != REG_X0) & (rs1_hit | rs2_hit);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the five-stage core: stage enables/flushes for load-use,
// taken branches, data-memory wait with timeout, and system-instruction halt.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_we,
    input  logic        ex_mem_re,
    input  logic        ex_branch_taken,
    input  logic        mem_mem_re,
    input  logic        mem_mem_we,
    input  logic        mem_sysi,
    input  logic        dmem_ack,
    input  logic        resume,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        dmem_req,
    output logic        halted,
    output logic        bus_err,
    output logic [31:0] stall_count
);

    // The timeout fires when the wait counter would step onto DMEM_TIMEOUT-1.
    localparam logic [7:0] WAIT_LAST = 8'(DMEM_TIMEOUT - 2);

    pipe_state_e state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] stall_count_q, stall_count_d;
    logic        bus_err_q, bus_err_d;
    logic        load_use;
    logic        mem_stall;

    hazard_detect u_hazard_detect (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_rd      (ex_rd),
        .ex_reg_we  (ex_reg_we),
        .ex_mem_re  (ex_mem_re),
        .load_use   (load_use)
    );

    // Next-state and zero-latency pipeline controls.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        dmem_req    = 1'b0;
        mem_stall   = 1'b0;
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        bus_err_d   = bus_err_q;

        case (state_q)
            RUN, MEM_WAIT: begin
                if (state_q == MEM_WAIT) begin
                    dmem_req  = 1'b1;
                    mem_stall = ~dmem_ack;
                end else begin
                    dmem_req  = mem_mem_re | mem_mem_we;
                    mem_stall = (mem_mem_re | mem_mem_we) & ~dmem_ack;
                end

                if (mem_stall) begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    id_ex_en  = 1'b0;
                    ex_mem_en = 1'b0;
                    mem_wb_en = 1'b0;
                    if (state_q == RUN) begin
                        state_d    = MEM_WAIT;
                        wait_cnt_d = 8'd0;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_d    = HALT;
                        wait_cnt_d = 8'd0;
                        bus_err_d  = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end else begin
                    // An ack out of MEM_WAIT resolves like RUN, so hazards held
                    // during the wait take effect in this same cycle.
                    if (state_q == MEM_WAIT) begin
                        state_d    = RUN;
                        wait_cnt_d = 8'd0;
                    end else begin
                        wait_cnt_d = wait_cnt_q;
                    end

                    if (mem_sysi) begin
                        pc_en     = 1'b0;
                        if_id_en  = 1'b0;
                        id_ex_en  = 1'b0;
                        ex_mem_en = 1'b0;
                        state_d   = HALT;
                    end else if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
            end
            HALT: begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
                mem_wb_en = 1'b0;
                if (resume) begin
                    state_d   = RUN;
                    bus_err_d = 1'b0;
                end else begin
                    state_d   = HALT;
                end
            end
            default: begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
                mem_wb_en = 1'b0;
                state_d   = RUN;
            end
        endcase

        if ((pc_en == 1'b0) && (state_q != HALT) && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end else begin
            stall_count_d = stall_count_q;
        end

        // Reset silences every control immediately, including an in-flight request.
        if (!rst) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_en     = 1'b0;
            if_id_flush   = 1'b0;
            id_ex_flush   = 1'b0;
            dmem_req      = 1'b0;
            state_d       = RUN;
            wait_cnt_d    = 8'd0;
            stall_count_d = 32'd0;
            bus_err_d     = 1'b0;
        end else begin
            bus_err_d = bus_err_d;
        end
    end

    // Status outputs are registered state, gated low while reset is held.
    always_comb begin
        halted      = rst & (state_q == HALT);
        bus_err     = rst & bus_err_q;
        stall_count = stall_count_q;
    end

    // State, counters and sticky status registers.
    always_ff @(posedge clk) begin
        state_q       <= state_d;
        wait_cnt_q    <= wait_cnt_d;
        stall_count_q <= stall_count_d;
        bus_err_q     <= bus_err_d;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with hand-computed control vectors.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_reg_we, ex_mem_re, ex_branch_taken;
    logic        mem_mem_re, mem_mem_we, mem_sysi, dmem_ack, resume;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, dmem_req, halted, bus_err;
    logic [31:0] stall_count;
    logic [9:0]  ctl;

    int n_checks = 0;
    int n_errors = 0;

    // {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id_flush, id_ex_flush, dmem_req, halted, bus_err}
    localparam logic [9:0] ALL_RUN  = 10'b11111_00_000;
    localparam logic [9:0] LU_STALL = 10'b00111_01_000;
    localparam logic [9:0] BR_FLUSH = 10'b11111_11_000;
    localparam logic [9:0] MEM_STL  = 10'b00000_00_100;
    localparam logic [9:0] MEM_ACK  = 10'b11111_00_100;
    localparam logic [9:0] HALT_ERR = 10'b00000_00_011;
    localparam logic [9:0] HALT_OK  = 10'b00000_00_010;
    localparam logic [9:0] SYSI     = 10'b00001_00_000;
    localparam logic [9:0] ALL_ZERO = 10'b00000_00_000;

    always #5 clk = ~clk;

    assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                  if_id_flush, id_ex_flush, dmem_req, halted, bus_err};

    pipe_hazard_ctrl #(.DMEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_mem_re(ex_mem_re),
        .ex_branch_taken(ex_branch_taken),
        .mem_mem_re(mem_mem_re), .mem_mem_we(mem_mem_we), .mem_sysi(mem_sysi),
        .dmem_ack(dmem_ack), .resume(resume),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .dmem_req(dmem_req), .halted(halted), .bus_err(bus_err), .stall_count(stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_reg_we = 1'b0; ex_mem_re = 1'b0; ex_branch_taken = 1'b0;
        mem_mem_re = 1'b0; mem_mem_we = 1'b0; mem_sysi = 1'b0;
        dmem_ack = 1'b0; resume = 1'b0;
    endtask

    // Step past the next rising edge; inputs are then driven and checked mid-cycle.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic load_in_ex(input logic [4:0] rd);
        ex_mem_re = 1'b1; ex_reg_we = 1'b1; ex_rd = rd;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        next(); #1;
        chk("rst_ctl", 32'(ctl), 32'(ALL_ZERO));
        next(); #1;
        chk("rst_cnt", stall_count, 32'd0);
        rst = 1'b1; #1;
        chk("idle_run", 32'(ctl), 32'(ALL_RUN));

        // load x5 in EX, ID add x6,x5,x1
        next(); load_in_ex(5'd5); id_rs1 = 5'd5; id_rs2 = 5'd1;
        id_use_rs1 = 1'b1; id_use_rs2 = 1'b1; #1;
        chk("lu_rs1", 32'(ctl), 32'(LU_STALL));
        next(); idle(); #1;
        chk("lu_after", 32'(ctl), 32'(ALL_RUN));
        chk("lu_cnt", stall_count, 32'd1);

        // load into x0 never stalls
        next(); load_in_ex(5'd0); id_use_rs1 = 1'b1; #1;
        chk("lu_x0", 32'(ctl), 32'(ALL_RUN));

        // rs2 dependency, then same regs but rs2 not read
        next(); idle(); load_in_ex(5'd7); id_rs2 = 5'd7; id_use_rs2 = 1'b1; #1;
        chk("lu_rs2", 32'(ctl), 32'(LU_STALL));
        next(); id_use_rs2 = 1'b0; #1;
        chk("lu_rs2_unused", 32'(ctl), 32'(ALL_RUN));
        chk("lu_cnt2", stall_count, 32'd2);

        // taken branch overrides load-use
        next(); id_use_rs2 = 1'b1; ex_branch_taken = 1'b1; #1;
        chk("br_over_lu", 32'(ctl), 32'(BR_FLUSH));
        next(); idle(); #1;
        chk("br_cnt", stall_count, 32'd2);

        // store, ack on the last cycle before timeout: success
        mem_mem_we = 1'b1; #1;
        chk("st_req1", 32'(ctl), 32'(MEM_STL));
        next(); #1;
        chk("st_req2", 32'(ctl), 32'(MEM_STL));
        next(); #1;
        chk("st_req3", 32'(ctl), 32'(MEM_STL));
        next(); dmem_ack = 1'b1; #1;
        chk("st_ack", 32'(ctl), 32'(MEM_ACK));
        next(); idle(); #1;
        chk("st_after", 32'(ctl), 32'(ALL_RUN));
        chk("st_cnt", stall_count, 32'd5);

        // load with no ack: timeout after 4 request cycles
        mem_mem_re = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("to_req%0d", i), 32'(ctl), 32'(MEM_STL));
            next();
        end
        #1;
        chk("to_halt", 32'(ctl), 32'(HALT_ERR));
        chk("to_cnt", stall_count, 32'd9);
        next(); #1;
        chk("halt_hold", 32'(ctl), 32'(HALT_ERR));
        chk("halt_cnt", stall_count, 32'd9);
        resume = 1'b1; #1;
        chk("resume_cyc", 32'(ctl), 32'(HALT_ERR));
        next(); idle(); #1;
        chk("resume_run", 32'(ctl), 32'(ALL_RUN));

        // resume outside HALT is ignored
        resume = 1'b1; #1;
        chk("resume_ign", 32'(ctl), 32'(ALL_RUN));

        // sysi beats a simultaneous branch
        next(); idle(); mem_sysi = 1'b1; ex_branch_taken = 1'b1; #1;
        chk("sysi", 32'(ctl), 32'(SYSI));
        next(); idle(); #1;
        chk("sysi_halt", 32'(ctl), 32'(HALT_OK));
        chk("sysi_cnt", stall_count, 32'd10);

        // reset while halted
        rst = 1'b0; #1;
        chk("rst_halt", 32'(ctl), 32'(ALL_ZERO));
        next(); rst = 1'b1; #1;
        chk("rst_halt_run", 32'(ctl), 32'(ALL_RUN));
        chk("rst_halt_cnt", stall_count, 32'd0);

        // reset during MEM_WAIT drops the request, no error
        mem_mem_we = 1'b1;
        next(); #1;
        chk("mw_req", 32'(ctl), 32'(MEM_STL));
        rst = 1'b0; #1;
        chk("mw_rst", 32'(ctl), 32'(ALL_ZERO));
        next(); rst = 1'b1; idle(); #1;
        chk("mw_rst_run", 32'(ctl), 32'(ALL_RUN));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
